// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Misses are serviced block-wise over a busywait handshake to main memory.
module data_cache_ctrl #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned INDEX_W  = 3,
  parameter int unsigned OFFSET_W = 2
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           READ,
  input  logic                           WRITE,
  input  logic [ADDR_W-1:0]              ADDRESS,
  input  logic [DATA_W-1:0]              WRITEDATA,
  output logic [DATA_W-1:0]              READDATA,
  output logic                           BUSYWAIT,
  output logic                           MEM_READ,
  output logic                           MEM_WRITE,
  output logic [ADDR_W-OFFSET_W-1:0]     MEM_ADDRESS,
  output logic [(DATA_W<<OFFSET_W)-1:0]  MEM_WRITEDATA,
  input  logic [(DATA_W<<OFFSET_W)-1:0]  MEM_READDATA,
  input  logic                           MEM_BUSYWAIT
);

  localparam int unsigned TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned LINES     = 1 << INDEX_W;
  localparam int unsigned BLOCK_W   = DATA_W << OFFSET_W;
  localparam int unsigned BLK_W     = ADDR_W - OFFSET_W;
  localparam int unsigned BYTE_SH   = $clog2(DATA_W);
  localparam int unsigned BIT_OFF_W = OFFSET_W + BYTE_SH;

  typedef enum logic [1:0] {StIdle, StWriteback, StFetch} state_e;

  state_e state_q, state_d;

  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];
  logic [BLK_W-1:0]   blk_q;

  logic [TAG_W-1:0]     req_tag;
  logic [INDEX_W-1:0]   req_idx;
  logic [OFFSET_W-1:0]  req_off;
  logic [BIT_OFF_W-1:0] bit_off;
  logic [INDEX_W-1:0]   blk_idx;
  logic [TAG_W-1:0]     blk_tag;
  logic                 req;
  logic                 hit;
  logic                 miss;
  logic                 wr_hit;
  logic                 fill;

  assign req_tag = ADDRESS[ADDR_W-1 -: TAG_W];
  assign req_idx = ADDRESS[OFFSET_W +: INDEX_W];
  assign req_off = ADDRESS[OFFSET_W-1:0];
  assign bit_off = {req_off, {BYTE_SH{1'b0}}};
  assign blk_idx = blk_q[INDEX_W-1:0];
  assign blk_tag = blk_q[BLK_W-1 -: TAG_W];

  assign req    = READ | WRITE;
  assign hit    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign miss   = (state_q == StIdle) && req && !hit;
  assign wr_hit = (state_q == StIdle) && WRITE && hit;

  assign BUSYWAIT = (state_q != StIdle) | miss;
  // Simultaneous READ and WRITE is a store, so no load data is returned.
  assign READDATA = ((state_q == StIdle) && READ && !WRITE && hit) ?
                    data_q[req_idx][bit_off +: DATA_W] : '0;

  always_comb begin
    state_d       = state_q;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    fill          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (miss) begin
          state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? StWriteback : StFetch;
        end
      end
      StWriteback: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tag_q[blk_idx], blk_idx};
        MEM_WRITEDATA = data_q[blk_idx];
        // A request withdrawn during the writeback skips the refill.
        if (!MEM_BUSYWAIT) state_d = req ? StFetch : StIdle;
      end
      StFetch: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = blk_q;
        if (!MEM_BUSYWAIT) begin
          fill    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The missing block address is captured so a wandering ADDRESS cannot corrupt the refill.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
      valid_q <= '0;
      dirty_q <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      if (miss) blk_q <= ADDRESS[ADDR_W-1:OFFSET_W];
      if (fill) begin
        data_q[blk_idx]  <= MEM_READDATA;
        tag_q[blk_idx]   <= blk_tag;
        valid_q[blk_idx] <= 1'b1;
        dirty_q[blk_idx] <= 1'b0;
      end else if (wr_hit) begin
        data_q[req_idx][bit_off +: DATA_W] <= WRITEDATA;
        dirty_q[req_idx]                   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Self-checking bench for data_cache_ctrl: directed table, hand sequences for the
// multi-cycle corners, and random traffic against a line-level cache model.
module tb_data_cache_ctrl;

  logic        CLK = 1'b0;
  logic        RESET, READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, MEM_READDATA;

  data_cache_ctrl dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_fail = 0;

  // Main memory: untouched blocks read back a fixed pattern, written blocks are remembered.
  logic [31:0] mem [64];
  bit          mem_wr [64];
  int          lat_cfg = 0;
  int          cnt;
  bit          served;

  function automatic logic [31:0] mem_init(input int a);
    case (a)
      1:       return 32'hDDCCBBAA;
      9:       return 32'h44332211;
      16:      return 32'h88776655;
      default: return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endcase
  endfunction

  function automatic logic [31:0] mem_rd(input logic [5:0] a);
    return mem_wr[a] ? mem[a] : mem_init(int'(a));
  endfunction

  // Each transfer is held busy for lat_cfg cycles, then completes on the following edge.
  always @(negedge CLK) begin
    if (!(MEM_READ || MEM_WRITE) || served) begin
      cnt    = lat_cfg;
      served = 1'b0;
    end
    if (MEM_READ || MEM_WRITE) begin
      if (cnt > 0) begin
        MEM_BUSYWAIT = 1'b1;
        cnt--;
      end else begin
        MEM_BUSYWAIT = 1'b0;
        served       = 1'b1;
        if (MEM_WRITE) begin
          mem[MEM_ADDRESS]    = MEM_WRITEDATA;
          mem_wr[MEM_ADDRESS] = 1'b1;
        end
        if (MEM_READ) MEM_READDATA = mem_rd(MEM_ADDRESS);
      end
    end else begin
      MEM_BUSYWAIT = 1'b0;
    end
  end

  bit          both_hi;
  int          wr_cycles;
  int          xfer_cycles;
  logic [5:0]  last_rd_addr, last_wr_addr;
  logic [31:0] last_wr_data;

  always @(negedge CLK) begin
    if (MEM_READ && MEM_WRITE) both_hi = 1'b1;
    if (MEM_READ || MEM_WRITE) xfer_cycles++;
    if (MEM_READ) last_rd_addr = MEM_ADDRESS;
    if (MEM_WRITE) begin
      wr_cycles++;
      last_wr_addr = MEM_ADDRESS;
      last_wr_data = MEM_WRITEDATA;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc_start();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
    READ = r; WRITE = w; ADDRESS = a; WRITEDATA = d;
    #2;
  endtask

  // Counts stall cycles, the miss cycle itself included; returns in the first non-busy cycle.
  task automatic wait_idle(output int cyc);
    cyc = 1;
    forever begin
      @(posedge CLK);
      #3;
      if (BUSYWAIT !== 1'b1) break;
      cyc++;
      if (cyc > 200) begin
        n_vec++;
        n_fail++;
        $display("FAIL miss_timeout: busy for %0d cycles, want idle", cyc);
        break;
      end
    end
  endtask

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_busy;
  } vec_t;

  // Reference cache state, kept as bytes per line.
  logic [7:0]  m_line [8][4];
  logic [2:0]  m_tag  [8];
  bit          m_valid [8];
  bit          m_dirty [8];
  logic [31:0] ref_mem [64];

  function automatic logic [31:0] pack(input logic [2:0] i);
    logic [31:0] b;
    for (int k = 0; k < 4; k++) b[8*k +: 8] = m_line[i][k];
    return b;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [6];
    int          c, nx, x0;
    logic [7:0]  a, d, exp;
    logic        r, w;
    logic [2:0]  ix, tg;
    logic [1:0]  of;
    logic [5:0]  ea;
    logic [31:0] blk;
    bit          hit;

    tbl[0] = '{1'b0, 1'b1, 8'h06, 8'h5A, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 8'h06, 8'h00, 8'h5A, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 8'h04, 8'h00, 8'hAA, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 8'h07, 8'h00, 8'hDD, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 8'h05, 8'h00, 8'hBB, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 8'h05, 8'h00, 8'h00, 1'b0};

    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    #2;
    chk("rst_busywait", BUSYWAIT, 0);
    chk("rst_mem_read", MEM_READ, 0);
    chk("rst_mem_write", MEM_WRITE, 0);
    chk("rst_mem_address", MEM_ADDRESS, 0);
    chk("rst_mem_writedata", MEM_WRITEDATA, 0);
    chk("rst_readdata", READDATA, 0);

    // Cold read miss, zero-wait memory.
    lat_cfg = 0;
    cyc_start();
    drive(1, 0, 8'h05, 8'h00);
    chk("t1_busy_same_cycle", BUSYWAIT, 1);
    chk("t1_no_mem_read_in_idle", MEM_READ, 0);
    wait_idle(c);
    chk("t1_latency", c, 2);
    chk("t1_fetch_addr", last_rd_addr, 6'h01);
    chk("t1_readdata", READDATA, 8'hBB);

    x0 = xfer_cycles;
    for (int i = 0; i < 6; i++) begin
      cyc_start();
      drive(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
      chk($sformatf("tbl%0d_busy", i), BUSYWAIT, tbl[i].exp_busy);
      chk($sformatf("tbl%0d_rdata", i), READDATA, tbl[i].exp_rdata);
    end
    chk("tbl_no_mem_traffic", xfer_cycles - x0, 0);

    // Dirty conflict miss: writeback then fetch.
    lat_cfg = 2;
    cyc_start();
    drive(1, 0, 8'h26, 8'h00);
    chk("t3_busy", BUSYWAIT, 1);
    wait_idle(c);
    chk("t3_latency", c, 7);
    chk("t3_wb_addr", last_wr_addr, 6'h01);
    chk("t3_wb_data", last_wr_data, 32'hDD5ABBAA);
    chk("t3_fetch_addr", last_rd_addr, 6'h09);
    chk("t3_readdata", READDATA, 8'h33);
    chk("t3_mem_holds_wb", mem_rd(6'h01), 32'hDD5ABBAA);

    // Clean write miss: fetch only, then the store lands as a hit.
    lat_cfg = 1;
    x0 = wr_cycles;
    cyc_start();
    drive(0, 1, 8'h41, 8'hE1);
    chk("t4_busy", BUSYWAIT, 1);
    wait_idle(c);
    chk("t4_latency", c, 3);
    chk("t4_no_writeback", wr_cycles - x0, 0);
    chk("t4_fetch_addr", last_rd_addr, 6'h10);
    cyc_start();
    drive(1, 0, 8'h41, 8'h00);
    chk("t4_byte1", READDATA, 8'hE1);
    cyc_start();
    drive(1, 0, 8'h40, 8'h00);
    chk("t4_byte0", READDATA, 8'h55);
    cyc_start();
    drive(1, 0, 8'h01, 8'h00);
    chk("t4_evict_busy", BUSYWAIT, 1);
    wait_idle(c);
    chk("t4_evict_latency", c, 5);
    chk("t4_wb_addr", last_wr_addr, 6'h10);
    chk("t4_wb_data", last_wr_data, 32'h8877E155);
    blk = mem_rd(6'h00);
    chk("t4_read01", READDATA, blk[15:8]);

    // Reset in the middle of a fetch.
    lat_cfg = 3;
    cyc_start();
    drive(1, 0, 8'h05, 8'h00);
    chk("t5_busy", BUSYWAIT, 1);
    cyc_start();
    #2;
    chk("t5_fetching", MEM_READ, 1);
    RESET = 1'b1;
    cyc_start();
    RESET = 1'b0;
    READ  = 1'b0;
    #2;
    chk("t5_mem_read_off", MEM_READ, 0);
    chk("t5_busy_off", BUSYWAIT, 0);
    chk("t5_mem_addr_zero", MEM_ADDRESS, 0);
    cyc_start();
    drive(1, 0, 8'h05, 8'h00);
    chk("t5_remiss", BUSYWAIT, 1);
    wait_idle(c);
    chk("t5_latency", c, 5);
    chk("t5_readdata", READDATA, 8'hBB);
    cyc_start();
    drive(1, 0, 8'h01, 8'h00);
    chk("t5_line0_invalidated", BUSYWAIT, 1);
    wait_idle(c);
    chk("t5_line0_latency", c, 5);

    // READ and WRITE together on a hit is a store.
    cyc_start();
    drive(1, 1, 8'h05, 8'h77);
    chk("t6_busy", BUSYWAIT, 0);
    chk("t6_rdata_zero", READDATA, 0);
    cyc_start();
    drive(1, 0, 8'h05, 8'h00);
    chk("t6_written", READDATA, 8'h77);
    cyc_start();
    drive(1, 0, 8'h06, 8'h00);
    chk("t6_neighbour", READDATA, 8'h5A);
    cyc_start();
    drive(0, 0, 8'h00, 8'h00);

    // Reset discards the dirty line: the conflicting miss must not write back.
    RESET = 1'b1;
    cyc_start();
    RESET = 1'b0;
    x0 = wr_cycles;
    drive(1, 0, 8'h25, 8'h00);
    chk("rd_busy", BUSYWAIT, 1);
    wait_idle(c);
    chk("rd_clean_latency", c, 5);
    chk("rd_no_writeback", wr_cycles - x0, 0);
    chk("rd_readdata", READDATA, 8'h22);

    // Random traffic against the model, starting from an empty cache.
    cyc_start();
    drive(0, 0, 8'h00, 8'h00);
    RESET = 1'b1;
    cyc_start();
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    for (int i = 0; i < 64; i++) ref_mem[i] = mem_rd(6'(i));

    for (int n = 0; n < 250; n++) begin
      lat_cfg = $urandom_range(0, 2);
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 255)) & 8'h7F;
      d = 8'($urandom_range(0, 255));
      ix = a[4:2];
      tg = a[7:5];
      of = a[1:0];
      drive(r, w, a, d);
      if (!r && !w) begin
        chk("rnd_idle_busy", BUSYWAIT, 0);
        chk("rnd_idle_rdata", READDATA, 0);
        cyc_start();
        continue;
      end
      hit = m_valid[ix] && (m_tag[ix] == tg);
      chk("rnd_busy", BUSYWAIT, !hit);
      if (!hit) begin
        nx = (m_valid[ix] && m_dirty[ix]) ? 2 : 1;
        ea = {m_tag[ix], ix};
        if (nx == 2) ref_mem[ea] = pack(ix);
        wait_idle(c);
        chk("rnd_latency", c, 1 + nx * (lat_cfg + 1));
        if (nx == 2) chk("rnd_writeback", mem_rd(ea), ref_mem[ea]);
        blk = ref_mem[{tg, ix}];
        for (int k = 0; k < 4; k++) m_line[ix][k] = blk[8*k +: 8];
        m_tag[ix]   = tg;
        m_valid[ix] = 1'b1;
        m_dirty[ix] = 1'b0;
      end
      exp = (r && !w) ? m_line[ix][of] : 8'h00;
      chk("rnd_rdata", READDATA, exp);
      if (w) begin
        m_line[ix][of] = d;
        m_dirty[ix]    = 1'b1;
      end
      cyc_start();
    end
    drive(0, 0, 8'h00, 8'h00);

    chk("mem_rd_wr_exclusive", both_hi, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
